te_mean_arbiter: RTL and testbench

- Shares one 3x3 mean-filter datapath (Q9 reciprocal, 57/512 ≈ 1/9) among NUM_REQ window producers, e.g. the R/G/B channel window generators of transmission estimation.
- Round-robin arbitration with burst locking; valid/ready handshake on every requester and on the output.
- One registered output stage, tagged with the source requester ID.
- Sits between the per-channel line-buffer/window blocks and the transmission-map combiner.

---
 rtl/te_pkg.sv | 33 +++
 rtl/te_mean9.sv | 22 ++
 rtl/te_mean_arbiter.sv | 112 +++++++++++
 tb/tb_te_mean_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// Shared constants and the round-robin search helper for the 3x3 mean-filter arbiter.
package te_pkg;

    localparam int unsigned MEAN_RECIP = 57;
    localparam int unsigned MEAN_SHIFT = 9;
    localparam int unsigned WIN_PIX    = 9;
    localparam int unsigned MAX_REQ    = 4;

    typedef logic [1:0] rr_idx_t;

    typedef struct packed {
        logic    found;
        rr_idx_t idx;
    } rr_pick_t;

    // First set bit of valid, searching ptr, ptr+1, ... modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] valid,
                                          input rr_idx_t ptr,
                                          input int unsigned n);
        rr_pick_t    pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !pick.found && valid[idx[1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = idx[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/te_mean9.sv
// Combinational 3x3 mean: sum of nine 8-bit pixels times 57, truncated by 9 bits.
module te_mean9
    import te_pkg::*;
(
    input  logic [WIN_PIX-1:0][7:0] i_pix,
    output logic [7:0]              o_mean
);

    logic [11:0] w_sum;
    logic [16:0] w_prod;

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < WIN_PIX; k++) begin
            w_sum = w_sum + 12'(i_pix[k]);
        end
    end

    assign w_prod = 17'(w_sum) * 17'(MEAN_RECIP);
    assign o_mean = w_prod[MEAN_SHIFT +: 8];

endmodule

// File: rtl/te_mean_arbiter.sv
// Round-robin, burst-locking arbiter sharing one te_mean9 datapath among NUM_REQ
// window producers, with a single registered, ID-tagged output stage.
module te_mean_arbiter
    import te_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIN_PIX*PIX_W-1:0] req_window,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PIX_W-1:0]               out_data,
    output logic [ID_W-1:0]                out_id
);

    localparam int unsigned WIN_W = WIN_PIX * PIX_W;

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_owner;
    logic [3:0]       r_cnt;
    logic             r_lock;
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_data;
    logic [ID_W-1:0]  r_out_id;

    logic [MAX_REQ-1:0]             w_vpad;
    rr_pick_t                       w_rr;
    logic                           w_can_accept;
    logic                           w_owner_hold;
    logic [ID_W-1:0]                w_grant;
    logic                           w_fire;
    logic [3:0]                     w_cnt_next;
    logic                           w_burst_done;
    logic [WIN_PIX-1:0][7:0]        w_win_sel;
    logic [7:0]                     w_mean;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] g);
        return (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        w_vpad = '0;
        w_vpad[NUM_REQ-1:0] = req_valid;
    end

    assign w_rr         = rr_first(w_vpad, rr_idx_t'(r_ptr), NUM_REQ);
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_owner_hold = r_lock && req_valid[r_owner] && (r_cnt < 4'(BURST_LEN));
    assign w_grant      = w_owner_hold ? r_owner : ID_W'(w_rr.idx);
    // Any valid requester guarantees the grant points at a valid one.
    assign w_fire       = w_can_accept && (|req_valid) && !rst;
    assign w_cnt_next   = (r_lock && w_grant == r_owner) ? r_cnt + 4'd1 : 4'd1;
    assign w_burst_done = (w_cnt_next == 4'(BURST_LEN));

    always_comb begin
        req_ready = '0;
        if (w_fire) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_win_sel = req_window[w_grant*WIN_W +: WIN_W];

    te_mean9 u_mean9 (
        .i_pix  (w_win_sel),
        .o_mean (w_mean)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_lock      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_can_accept) begin
            // Release first; an accept on the same edge overrides lock/ptr.
            if (r_lock && !req_valid[r_owner]) begin
                r_lock <= 1'b0;
                r_ptr  <= next_idx(r_owner);
            end
            if (w_fire) begin
                r_owner     <= w_grant;
                r_cnt       <= w_cnt_next;
                r_out_valid <= 1'b1;
                r_out_data  <= PIX_W'(w_mean);
                r_out_id    <= w_grant;
                if (w_burst_done) begin
                    r_lock <= 1'b0;
                    r_ptr  <= next_idx(w_grant);
                end else begin
                    r_lock <= 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_te_mean_arbiter.sv
// Scoreboard bench for te_mean_arbiter: a spec-level arbitration model predicts req_ready,
// accepted windows are queued with their expected mean and checked as results emerge.
module tb_te_mean_arbiter;

    localparam int NUM_REQ = 3;
    localparam int BURST   = 4;

    typedef struct {
        int id;
        int data;
    } sb_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*72-1:0]  req_window;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic [1:0]             out_id;

    te_mean_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PIX_W     (8),
        .BURST_LEN (BURST),
        .ID_W      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_window (req_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;

    logic [7:0] win [NUM_REQ][9];
    bit  auto_rand = 0;
    sb_t sb [$];
    int  id_log [$];

    // spec-level arbitration/output model
    int m_ptr, m_cnt, m_owner;
    bit m_lock, m_ov;
    bit prev_stall;
    logic [7:0] hold_data;
    logic [1:0] hold_id;

    function automatic int mean9(input int r);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(win[r][k]);
        return (s * 57) >> 9;
    endfunction

    function automatic int m_grant();
        if (m_lock && req_valid[m_owner] && m_cnt < BURST) return m_owner;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[(m_ptr + i) % NUM_REQ]) return (m_ptr + i) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic pack();
        for (int r = 0; r < NUM_REQ; r++)
            for (int k = 0; k < 9; k++)
                req_window[(r*9+k)*8 +: 8] = win[r][k];
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_owner = 0; m_lock = 0; m_ov = 0;
        prev_stall = 0;
        sb.delete();
    endtask

    task automatic cycle();
        bit can, fire, lock0;
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        sb_t e;
        pack();
        @(negedge clk);
        can  = !m_ov || out_ready;
        g    = m_grant();
        fire = can && (|req_valid) && !rst;
        exp_rdy = fire ? NUM_REQ'(1 << g) : '0;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
        end
        n_vec++;
        if (out_valid !== m_ov) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
        end
        if (out_valid === 1'b1 && prev_stall) begin
            n_vec++;
            if (out_data !== hold_data || out_id !== hold_id) begin
                n_err++;
                $display("FAIL stall_hold: got data %0d id %0d expected data %0d id %0d",
                         out_data, out_id, hold_data, hold_id);
            end
        end
        if (out_valid === 1'b1 && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: got result data %0d id %0d expected none", out_data, out_id);
            end else begin
                e = sb.pop_front();
                n_pop++;
                if (out_data !== 8'(e.data) || out_id !== 2'(e.id)) begin
                    n_err++;
                    $display("FAIL result: got data %0d id %0d expected data %0d id %0d",
                             out_data, out_id, e.data, e.id);
                end
            end
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        hold_data  = out_data;
        hold_id    = out_id;
        if (fire) begin
            e.id = g;
            e.data = mean9(g);
            sb.push_back(e);
            n_push++;
            id_log.push_back(g);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (can) begin
            lock0 = m_lock;
            if (m_lock && !req_valid[m_owner]) begin
                m_lock = 0;
                m_ptr  = (m_owner + 1) % NUM_REQ;
            end
            if (fire) begin
                if (lock0 && g == m_owner) m_cnt++;
                else begin m_owner = g; m_cnt = 1; m_lock = 1; end
                if (m_cnt == BURST) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % NUM_REQ;
                end
                m_ov = 1;
            end else begin
                m_ov = 0;
            end
        end
        #1;
        if (auto_rand && fire) begin
            for (int k = 0; k < 9; k++) win[g][k] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; out_ready = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) for (int k = 0; k < 9; k++) win[r][k] = 8'd0;
        pack();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_id !== 2'd0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v%b d%0d id%0d rdy%b expected v0 d0 id0 rdy000",
                     out_valid, out_data, out_id, req_ready);
        end
        req_valid = '1;
        cycle();
        rst = 1'b0;
        req_valid = '0;
        cycle();
    endtask

    task automatic test_single_b2b();
        int n0;
        for (int k = 0; k < 9; k++) win[0][k] = 8'd100;
        req_valid = 3'b001;
        cycle();
        req_valid = '0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'd100 || out_id !== 2'd0) begin
            n_err++;
            $display("FAIL single_r0: got v%b d%0d id%0d expected v1 d100 id0",
                     out_valid, out_data, out_id);
        end
        repeat (2) cycle();
        n0 = n_pop;
        auto_rand = 1;
        req_valid = 3'b001;
        repeat (8) cycle();
        req_valid = '0;
        cycle();
        auto_rand = 0;
        n_vec++;
        if (n_pop - n0 != 8) begin
            n_err++;
            $display("FAIL b2b_throughput: got %0d results expected 8", n_pop - n0);
        end
    endtask

    task automatic test_patterns();
        for (int k = 0; k < 9; k++) begin
            win[1][k] = 8'(k + 1);
            win[2][k] = 8'd255;
        end
        req_valid = 3'b010;
        cycle();
        n_vec++;
        if (out_data !== 8'd5 || out_id !== 2'd1) begin
            n_err++;
            $display("FAIL pattern_r1: got d%0d id%0d expected d5 id1", out_data, out_id);
        end
        req_valid = 3'b100;
        cycle();
        n_vec++;
        if (out_data !== 8'd255 || out_id !== 2'd2) begin
            n_err++;
            $display("FAIL pattern_r2: got d%0d id%0d expected d255 id2", out_data, out_id);
        end
        req_valid = '0;
        repeat (2) cycle();
    endtask

    task automatic test_burst();
        int exp_ids [13] = '{0,0,0,0,1,1,1,1,2,2,2,2,0};
        do_reset();
        id_log.delete();
        auto_rand = 1;
        req_valid = 3'b111;
        repeat (13) cycle();
        req_valid = '0;
        repeat (2) cycle();
        auto_rand = 0;
        for (int i = 0; i < 13; i++) begin
            n_vec++;
            if (i >= id_log.size() || id_log[i] != exp_ids[i]) begin
                n_err++;
                $display("FAIL burst_id[%0d]: got %0d expected %0d", i,
                         (i < id_log.size()) ? id_log[i] : -1, exp_ids[i]);
            end
        end
    endtask

    task automatic test_stall();
        auto_rand = 1;
        req_valid = 3'b111;
        out_ready = 1'b1;
        repeat (2) cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (6) cycle();
        req_valid = '0;
        repeat (2) cycle();
        auto_rand = 0;
        n_vec++;
        if (sb.size() != 0 || n_push != n_pop) begin
            n_err++;
            $display("FAIL stall_count: got pushed %0d popped %0d left %0d expected equal and 0 left",
                     n_push, n_pop, sb.size());
        end
    endtask

    task automatic test_drop();
        int exp_ids [3] = '{0,0,1};
        do_reset();
        id_log.delete();
        req_valid = 3'b001;
        repeat (2) cycle();
        req_valid = 3'b000;
        cycle();
        req_valid = 3'b111;
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= id_log.size() || id_log[i] != exp_ids[i]) begin
                n_err++;
                $display("FAIL drop_id[%0d]: got %0d expected %0d", i,
                         (i < id_log.size()) ? id_log[i] : -1, exp_ids[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        auto_rand = 1;
        req_valid = 3'b111;
        repeat (6) cycle();
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_valid: got %b expected 0", out_valid);
        end
        id_log.delete();
        req_valid = 3'b110;
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        auto_rand = 0;
        n_vec++;
        if (id_log.size() == 0 || id_log[0] != 1) begin
            n_err++;
            $display("FAIL rst_mid_grant: got %0d expected 1",
                     (id_log.size() != 0) ? id_log[0] : -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_b2b();
        test_patterns();
        test_burst();
        test_stall();
        test_drop();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
